// File: rtl/riscv_axi_dram_window.sv
// riscv_axi_dram_window: relocates Rocket DRAM-window AXI traffic onto the board's
// shared-DRAM window and terminates out-of-window accesses locally with DECERR.

module riscv_axi_dram_window_slice #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_pop
);
  logic         r_live, r_vld, r_skid_vld;
  logic [W-1:0] r_data, r_skid;

  // ready depends only on the skid entry, so no combinational path from i_pop
  assign o_ready = r_live & ~r_skid_vld;
  assign o_valid = r_vld;
  assign o_data  = r_data;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_live     <= 1'b0;
      r_vld      <= 1'b0;
      r_skid_vld <= 1'b0;
      r_data     <= '0;
      r_skid     <= '0;
    end else begin
      r_live <= 1'b1;
      if (r_skid_vld) begin
        if (i_pop) begin
          r_data     <= r_skid;
          r_skid_vld <= 1'b0;
        end
      end else if (i_valid && r_live) begin
        if (!r_vld || i_pop) begin
          r_data <= i_data;
          r_vld  <= 1'b1;
        end else begin
          r_skid     <= i_data;
          r_skid_vld <= 1'b1;
        end
      end else if (i_pop) begin
        r_vld <= 1'b0;
      end
    end
  end
endmodule

module riscv_axi_dram_window #(
  parameter int                 ID_W      = 6,
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 64,
  parameter logic [ADDR_W-1:0]  CORE_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0]  DRAM_BASE = 32'h3E00_0000,
  parameter int                 DRAM_BITS = 25,
  parameter int                 MAX_OUT   = 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awlock,
  input  logic [3:0]          s_axi_awcache,
  input  logic [2:0]          s_axi_awprot,
  input  logic [3:0]          s_axi_awqos,
  input  logic [3:0]          s_axi_awregion,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic [2:0]          s_axi_arprot,
  input  logic [3:0]          s_axi_arqos,
  input  logic [3:0]          s_axi_arregion,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic [3:0]          m_axi_awregion,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic [3:0]          m_axi_arqos,
  output logic [3:0]          m_axi_arregion,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);
  localparam logic [ADDR_W-1:0] LOW_MASK = {ADDR_W{1'b1}} >> (ADDR_W - DRAM_BITS);
  localparam logic [3:0]        MAX_CNT  = 4'(MAX_OUT);

  typedef struct packed {
    logic              hit;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
  } ax_t;

  typedef enum logic [1:0] {W_PASS, W_DRAIN, W_RESP} wst_t;
  typedef enum logic       {R_PASS, R_ERR}           rdst_t;

  // Only the start address is decoded; a legal burst cannot cross 4 KB, so it stays in the window.
  function automatic logic f_hit(input logic [ADDR_W-1:0] a);
    return (a >> DRAM_BITS) == (CORE_BASE >> DRAM_BITS);
  endfunction

  function automatic logic [ADDR_W-1:0] f_reloc(input logic [ADDR_W-1:0] a);
    return DRAM_BASE | (a & LOW_MASK);
  endfunction

  ax_t [1:0]  w_ax_in, w_head;
  logic [1:0] w_in_vld, w_rdy, w_head_vld, w_pop;
  logic       r_live;
  wst_t       r_wst, w_wst_nxt;
  rdst_t      r_rst, w_rst_nxt;
  logic [3:0] r_wcnt, r_rcnt;
  logic [8:0] r_wbeats;
  logic [7:0] r_rbeats;
  logic [ID_W-1:0] r_bid, r_rid;
  logic       w_aw_fwd, w_aw_miss, w_ar_fwd, w_ar_miss;
  logic       w_aw_hs, w_b_hs, w_ar_hs, w_rl_hs;

  always_comb begin
    w_ax_in[0] = '{hit: f_hit(s_axi_awaddr), id: s_axi_awid, addr: f_reloc(s_axi_awaddr),
                   len: s_axi_awlen, size: s_axi_awsize, burst: s_axi_awburst,
                   lock: s_axi_awlock, cache: s_axi_awcache, prot: s_axi_awprot,
                   qos: s_axi_awqos, region: s_axi_awregion};
    w_ax_in[1] = '{hit: f_hit(s_axi_araddr), id: s_axi_arid, addr: f_reloc(s_axi_araddr),
                   len: s_axi_arlen, size: s_axi_arsize, burst: s_axi_arburst,
                   lock: s_axi_arlock, cache: s_axi_arcache, prot: s_axi_arprot,
                   qos: s_axi_arqos, region: s_axi_arregion};
  end

  assign w_in_vld = {s_axi_arvalid, s_axi_awvalid};
  assign s_axi_awready = w_rdy[0];
  assign s_axi_arready = w_rdy[1];

  // index 0 = AW, 1 = AR
  for (genvar g = 0; g < 2; g++) begin : g_slice
    riscv_axi_dram_window_slice #(.W($bits(ax_t))) u_slice (
      .aclk    (aclk),
      .aresetn (aresetn),
      .i_data  (w_ax_in[g]),
      .i_valid (w_in_vld[g]),
      .o_ready (w_rdy[g]),
      .o_data  (w_head[g]),
      .o_valid (w_head_vld[g]),
      .i_pop   (w_pop[g])
    );
  end

  // A miss waits at the head until its direction is idle so per-ID ordering holds.
  assign w_aw_fwd  = w_head_vld[0] &  w_head[0].hit & (r_wst == W_PASS) & (r_wcnt != MAX_CNT);
  assign w_aw_miss = w_head_vld[0] & ~w_head[0].hit & (r_wst == W_PASS) & (r_wcnt == 4'd0);
  assign w_ar_fwd  = w_head_vld[1] &  w_head[1].hit & (r_rst == R_PASS) & (r_rcnt != MAX_CNT);
  assign w_ar_miss = w_head_vld[1] & ~w_head[1].hit & (r_rst == R_PASS) & (r_rcnt == 4'd0);
  assign w_pop[0]  = (w_aw_fwd & m_axi_awready) | w_aw_miss;
  assign w_pop[1]  = (w_ar_fwd & m_axi_arready) | w_ar_miss;

  assign m_axi_awvalid  = w_aw_fwd;
  assign m_axi_awid     = w_head[0].id;
  assign m_axi_awaddr   = w_head[0].addr;
  assign m_axi_awlen    = w_head[0].len;
  assign m_axi_awsize   = w_head[0].size;
  assign m_axi_awburst  = w_head[0].burst;
  assign m_axi_awlock   = w_head[0].lock;
  assign m_axi_awcache  = w_head[0].cache;
  assign m_axi_awprot   = w_head[0].prot;
  assign m_axi_awqos    = w_head[0].qos;
  assign m_axi_awregion = w_head[0].region;
  assign m_axi_arvalid  = w_ar_fwd;
  assign m_axi_arid     = w_head[1].id;
  assign m_axi_araddr   = w_head[1].addr;
  assign m_axi_arlen    = w_head[1].len;
  assign m_axi_arsize   = w_head[1].size;
  assign m_axi_arburst  = w_head[1].burst;
  assign m_axi_arlock   = w_head[1].lock;
  assign m_axi_arcache  = w_head[1].cache;
  assign m_axi_arprot   = w_head[1].prot;
  assign m_axi_arqos    = w_head[1].qos;
  assign m_axi_arregion = w_head[1].region;

  assign w_aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_b_hs  = m_axi_bvalid & m_axi_bready;
  assign w_ar_hs = m_axi_arvalid & m_axi_arready;
  assign w_rl_hs = m_axi_rvalid & m_axi_rready & m_axi_rlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_live   <= 1'b0;
      r_wst    <= W_PASS;
      r_rst    <= R_PASS;
      r_wcnt   <= 4'd0;
      r_rcnt   <= 4'd0;
      r_wbeats <= 9'd0;
      r_rbeats <= 8'd0;
      r_bid    <= '0;
      r_rid    <= '0;
    end else begin
      r_live <= 1'b1;
      r_wst  <= w_wst_nxt;
      r_rst  <= w_rst_nxt;
      if (w_aw_hs && !w_b_hs)      r_wcnt <= r_wcnt + 4'd1;
      else if (!w_aw_hs && w_b_hs) r_wcnt <= r_wcnt - 4'd1;
      if (w_ar_hs && !w_rl_hs)      r_rcnt <= r_rcnt + 4'd1;
      else if (!w_ar_hs && w_rl_hs) r_rcnt <= r_rcnt - 4'd1;
      if (w_aw_miss) begin
        r_bid    <= w_head[0].id;
        r_wbeats <= {1'b0, w_head[0].len} + 9'd1;
      end else if (r_wst == W_DRAIN && s_axi_wvalid) begin
        r_wbeats <= r_wbeats - 9'd1;
      end
      if (w_ar_miss) begin
        r_rid    <= w_head[1].id;
        r_rbeats <= w_head[1].len;
      end else if (r_rst == R_ERR && s_axi_rready && r_rbeats != 8'd0) begin
        r_rbeats <= r_rbeats - 8'd1;
      end
    end
  end

  always_comb begin
    w_wst_nxt    = r_wst;
    m_axi_wvalid = 1'b0;
    m_axi_wdata  = '0;
    m_axi_wstrb  = '0;
    m_axi_wlast  = 1'b0;
    s_axi_wready = 1'b0;
    s_axi_bvalid = 1'b0;
    s_axi_bresp  = 2'b00;
    s_axi_bid    = '0;
    m_axi_bready = 1'b0;
    case (r_wst)
      W_PASS: begin
        if (r_live) begin
          m_axi_wvalid = s_axi_wvalid;
          m_axi_wdata  = s_axi_wdata;
          m_axi_wstrb  = s_axi_wstrb;
          m_axi_wlast  = s_axi_wlast;
          s_axi_wready = m_axi_wready;
          s_axi_bvalid = m_axi_bvalid;
          s_axi_bresp  = m_axi_bresp;
          s_axi_bid    = m_axi_bid;
          m_axi_bready = s_axi_bready;
        end
        if (w_aw_miss) w_wst_nxt = W_DRAIN;
      end
      W_DRAIN: begin
        s_axi_wready = 1'b1;
        // the beat count backs up wlast in case the core never raises it
        if (s_axi_wvalid && (s_axi_wlast || r_wbeats == 9'd1)) w_wst_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = 2'b11;
        s_axi_bid    = r_bid;
        if (s_axi_bready) w_wst_nxt = W_PASS;
      end
      default: w_wst_nxt = W_PASS;
    endcase
  end

  always_comb begin
    w_rst_nxt    = r_rst;
    s_axi_rvalid = 1'b0;
    s_axi_rid    = '0;
    s_axi_rdata  = '0;
    s_axi_rresp  = 2'b00;
    s_axi_rlast  = 1'b0;
    m_axi_rready = 1'b0;
    case (r_rst)
      R_PASS: begin
        if (r_live) begin
          s_axi_rvalid = m_axi_rvalid;
          s_axi_rid    = m_axi_rid;
          s_axi_rdata  = m_axi_rdata;
          s_axi_rresp  = m_axi_rresp;
          s_axi_rlast  = m_axi_rlast;
          m_axi_rready = s_axi_rready;
        end
        if (w_ar_miss) w_rst_nxt = R_ERR;
      end
      R_ERR: begin
        s_axi_rvalid = 1'b1;
        s_axi_rid    = r_rid;
        s_axi_rresp  = 2'b11;
        s_axi_rlast  = (r_rbeats == 8'd0);
        if (s_axi_rready && r_rbeats == 8'd0) w_rst_nxt = R_PASS;
      end
      default: w_rst_nxt = R_PASS;
    endcase
  end
endmodule

// File: tb/tb_riscv_axi_dram_window.sv
// Directed bench for riscv_axi_dram_window: hit relocation, DECERR termination,
// outstanding throttle and asynchronous reset.
module tb_riscv_axi_dram_window;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [5:0]  s_axi_awid = '0, s_axi_arid = '0;
  logic [31:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [7:0]  s_axi_awlen = '0, s_axi_arlen = '0;
  logic [2:0]  s_axi_awsize = 3'd3, s_axi_arsize = 3'd3;
  logic [1:0]  s_axi_awburst = 2'd1, s_axi_arburst = 2'd1;
  logic        s_axi_awlock = 1'b0, s_axi_arlock = 1'b0;
  logic [3:0]  s_axi_awcache = 4'h3, s_axi_arcache = 4'h3;
  logic [2:0]  s_axi_awprot = '0, s_axi_arprot = '0;
  logic [3:0]  s_axi_awqos = '0, s_axi_arqos = '0;
  logic [3:0]  s_axi_awregion = '0, s_axi_arregion = '0;
  logic        s_axi_awvalid = 1'b0, s_axi_arvalid = 1'b0;
  logic        s_axi_awready, s_axi_arready;
  logic [63:0] s_axi_wdata = '0;
  logic [7:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_wready;
  logic [5:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready = 1'b0;
  logic [5:0]  s_axi_rid;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0;
  logic [5:0]  m_axi_awid, m_axi_arid;
  logic [31:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize;
  logic [1:0]  m_axi_awburst, m_axi_arburst;
  logic        m_axi_awlock, m_axi_arlock;
  logic [3:0]  m_axi_awcache, m_axi_arcache;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_awqos, m_axi_arqos;
  logic [3:0]  m_axi_awregion, m_axi_arregion;
  logic        m_axi_awvalid, m_axi_arvalid;
  logic        m_axi_awready = 1'b1, m_axi_arready = 1'b1;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready = 1'b1;
  logic [5:0]  m_axi_bid = '0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0, m_axi_bready;
  logic [5:0]  m_axi_rid = '0;
  logic [63:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_rready;

  int n_chk = 0;
  int n_err = 0;
  int n_arfwd = 0;
  int base;

  riscv_axi_dram_window dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awregion(s_axi_awregion), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arregion(s_axi_arregion), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awregion(m_axi_awregion), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) if (m_axi_arvalid && m_axi_arready) n_arfwd <= n_arfwd + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  initial begin
    // reset with hostile inputs on every channel
    s_axi_wvalid = 1'b1; s_axi_wdata = 64'hFFFF; s_axi_arvalid = 1'b1; s_axi_awvalid = 1'b1;
    m_axi_bvalid = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 64'h1234;
    #12;
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_wready",  s_axi_wready, 0);
    chk("rst_m_awvld", m_axi_awvalid, 0);
    chk("rst_m_arvld", m_axi_arvalid, 0);
    chk("rst_m_wvld",  m_axi_wvalid, 0);
    chk("rst_m_wdata", m_axi_wdata, 0);
    chk("rst_bvalid",  s_axi_bvalid, 0);
    chk("rst_rvalid",  s_axi_rvalid, 0);
    chk("rst_rdata",   s_axi_rdata, 0);
    s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_arvalid = 0; s_axi_awvalid = 0;
    m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_rdata = 0;
    @(negedge aclk); aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // write hit
    s_axi_awvalid = 1; s_axi_awaddr = 32'h8000_1000; s_axi_awlen = 3; s_axi_awid = 3;
    #1 chk("wh_awready", s_axi_awready, 1);
    @(negedge aclk); s_axi_awvalid = 0;
    chk("wh_m_awvld", m_axi_awvalid, 1);
    chk("wh_m_awaddr", m_axi_awaddr, 32'h3E00_1000);
    chk("wh_m_awid", m_axi_awid, 3);
    chk("wh_m_awlen", m_axi_awlen, 3);
    chk("wh_m_awcache", m_axi_awcache, 4'h3);
    @(negedge aclk);
    chk("wh_aw_once", m_axi_awvalid, 0);
    for (int i = 0; i < 4; i++) begin
      s_axi_wvalid = 1; s_axi_wdata = 64'h1111_0000_0000_0000 + 64'(i);
      s_axi_wstrb = 8'hFF; s_axi_wlast = (i == 3);
      #1;
      chk("wh_m_wvld", m_axi_wvalid, 1);
      chk("wh_m_wdata", m_axi_wdata, 64'h1111_0000_0000_0000 + 64'(i));
      chk("wh_m_wlast", m_axi_wlast, (i == 3));
      chk("wh_s_wready", s_axi_wready, 1);
      @(negedge aclk);
    end
    s_axi_wvalid = 0; s_axi_wlast = 0;
    m_axi_bvalid = 1; m_axi_bid = 3; m_axi_bresp = 0; s_axi_bready = 1;
    #1;
    chk("wh_bvalid", s_axi_bvalid, 1);
    chk("wh_bid", s_axi_bid, 3);
    chk("wh_bresp", s_axi_bresp, 0);
    chk("wh_m_bready", m_axi_bready, 1);
    @(negedge aclk); m_axi_bvalid = 0; s_axi_bready = 0;

    // read hit under backpressure
    s_axi_arvalid = 1; s_axi_araddr = 32'h81FF_FFF8; s_axi_arlen = 0; s_axi_arid = 4;
    @(negedge aclk); s_axi_arvalid = 0;
    chk("rh_m_arvld", m_axi_arvalid, 1);
    chk("rh_m_araddr", m_axi_araddr, 32'h3FFF_FFF8);
    @(negedge aclk);
    m_axi_rvalid = 1; m_axi_rdata = 64'hDEAD_BEEF_0123_4567; m_axi_rlast = 1; m_axi_rid = 4;
    for (int k = 0; k < 3; k++) begin
      s_axi_rready = (k == 2);
      #1;
      chk("rh_rvalid", s_axi_rvalid, 1);
      chk("rh_rdata", s_axi_rdata, 64'hDEAD_BEEF_0123_4567);
      chk("rh_rlast", s_axi_rlast, 1);
      chk("rh_m_rready", m_axi_rready, (k == 2));
      @(negedge aclk);
    end
    m_axi_rvalid = 0; m_axi_rlast = 0; s_axi_rready = 0;

    // write miss
    s_axi_awvalid = 1; s_axi_awaddr = 32'h4000_0000; s_axi_awlen = 7; s_axi_awid = 5;
    @(negedge aclk); s_axi_awvalid = 0;
    chk("wm_no_aw0", m_axi_awvalid, 0);
    @(negedge aclk);
    chk("wm_no_aw1", m_axi_awvalid, 0);
    for (int i = 0; i < 8; i++) begin
      s_axi_wvalid = 1; s_axi_wdata = 64'(i); s_axi_wlast = (i == 7);
      #1;
      chk("wm_wready", s_axi_wready, 1);
      chk("wm_no_wvld", m_axi_wvalid, 0);
      @(negedge aclk);
    end
    s_axi_wvalid = 0; s_axi_wlast = 0;
    chk("wm_bvalid", s_axi_bvalid, 1);
    chk("wm_bresp", s_axi_bresp, 2'b11);
    chk("wm_bid", s_axi_bid, 5);
    chk("wm_m_bready", m_axi_bready, 0);
    @(negedge aclk);
    chk("wm_bvalid_hold", s_axi_bvalid, 1);
    s_axi_bready = 1;
    @(negedge aclk); s_axi_bready = 0;
    chk("wm_bvalid_done", s_axi_bvalid, 0);

    // read miss queued behind an outstanding hit
    s_axi_arvalid = 1; s_axi_araddr = 32'h8000_0040; s_axi_arlen = 0; s_axi_arid = 1;
    @(negedge aclk);
    s_axi_araddr = 32'h1000_0000; s_axi_arlen = 2; s_axi_arid = 2;
    chk("rm_hit_addr", m_axi_araddr, 32'h3E00_0040);
    @(negedge aclk); s_axi_arvalid = 0;
    for (int k = 0; k < 3; k++) begin
      chk("rm_miss_wait", s_axi_rvalid, 0);
      chk("rm_no_fwd", m_axi_arvalid, 0);
      @(negedge aclk);
    end
    m_axi_rvalid = 1; m_axi_rid = 1; m_axi_rlast = 1; m_axi_rdata = 64'h55; s_axi_rready = 1;
    #1;
    chk("rm_hit_rid", s_axi_rid, 1);
    chk("rm_hit_resp", s_axi_rresp, 0);
    @(negedge aclk); m_axi_rvalid = 0; m_axi_rlast = 0;
    #1 chk("rm_gap", s_axi_rvalid, 0);
    @(negedge aclk);
    s_axi_rready = 0;
    #1;
    chk("rm_stall_vld", s_axi_rvalid, 1);
    chk("rm_stall_last", s_axi_rlast, 0);
    @(negedge aclk);
    s_axi_rready = 1;
    for (int b = 0; b < 3; b++) begin
      #1;
      chk("rm_rvalid", s_axi_rvalid, 1);
      chk("rm_rid", s_axi_rid, 2);
      chk("rm_rresp", s_axi_rresp, 2'b11);
      chk("rm_rdata", s_axi_rdata, 0);
      chk("rm_rlast", s_axi_rlast, (b == 2));
      @(negedge aclk);
    end
    chk("rm_done", s_axi_rvalid, 0);
    s_axi_rready = 0;

    // throttle at MAX_OUT outstanding reads
    base = n_arfwd;
    for (int i = 0; i < 9; i++) begin
      s_axi_arvalid = 1; s_axi_araddr = 32'h8000_0000 + 32'(i * 64);
      s_axi_arlen = 0; s_axi_arid = 6'(i);
      #1 chk("thr_ardy", s_axi_arready, 1);
      @(negedge aclk);
    end
    s_axi_arvalid = 0;
    repeat (3) @(negedge aclk);
    chk("thr_fwd8", 64'(n_arfwd - base), 8);
    chk("thr_hold", m_axi_arvalid, 0);
    m_axi_rvalid = 1; m_axi_rlast = 1; m_axi_rid = 0; s_axi_rready = 1;
    @(negedge aclk); m_axi_rvalid = 0;
    #1;
    chk("thr_9th_vld", m_axi_arvalid, 1);
    chk("thr_9th_id", m_axi_arid, 8);
    @(negedge aclk);
    chk("thr_fwd9", 64'(n_arfwd - base), 9);
    for (int i = 1; i < 9; i++) begin
      m_axi_rvalid = 1; m_axi_rid = 6'(i);
      @(negedge aclk);
    end
    m_axi_rvalid = 0; m_axi_rlast = 0; s_axi_rready = 0;

    // async reset while draining a miss write
    s_axi_awvalid = 1; s_axi_awaddr = 32'h0000_2000; s_axi_awlen = 3; s_axi_awid = 6;
    @(negedge aclk); s_axi_awvalid = 0;
    @(negedge aclk);
    s_axi_wvalid = 1; s_axi_wlast = 0;
    #1 chk("ar_drain_wready", s_axi_wready, 1);
    @(negedge aclk);
    #2 aresetn = 0;
    #1;
    chk("ar_wready", s_axi_wready, 0);
    chk("ar_m_wvld", m_axi_wvalid, 0);
    chk("ar_bvalid", s_axi_bvalid, 0);
    chk("ar_awready", s_axi_awready, 0);
    @(negedge aclk); s_axi_wvalid = 0; aresetn = 1;
    repeat (2) @(negedge aclk);
    s_axi_wvalid = 1; m_axi_wready = 0;
    #1;
    chk("ar_pass_wvld", m_axi_wvalid, 1);
    chk("ar_pass_wrdy", s_axi_wready, 0);
    s_axi_wvalid = 0; m_axi_wready = 1;
    // a miss is only accepted with wcnt == 0
    s_axi_awvalid = 1; s_axi_awaddr = 32'h0000_3000; s_axi_awlen = 0; s_axi_awid = 7;
    @(negedge aclk); s_axi_awvalid = 0;
    @(negedge aclk);
    s_axi_wvalid = 1; s_axi_wlast = 1;
    @(negedge aclk); s_axi_wvalid = 0; s_axi_wlast = 0; s_axi_bready = 1;
    #1;
    chk("ar_miss_bvld", s_axi_bvalid, 1);
    chk("ar_miss_bid", s_axi_bid, 7);
    chk("ar_miss_bresp", s_axi_bresp, 2'b11);
    @(negedge aclk); s_axi_bready = 0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
